mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WD_LIMIT, default 255: the number of consecutive cycles an access may stay pending before the watchdog fires.
REQ-002 SHALL have CLK  in  1  single clock; the block samples its inputs and updates on the rising edge.
REQ-003 SHALL have nRST  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have iREN  in  1 (instruction read request) and iaddr  in  32 (instruction word address).
REQ-005 SHALL have iload  out  32 (registered instruction data) and ihit  out  1 (instruction access complete).
REQ-006 SHALL have dREN  in  1 (data read request), dWEN  in  1 (data write request), daddr  in  32 (data address) and dstore  in  32 (write data).
REQ-007 SHALL have dload  out  32 (registered read data) and dhit  out  1 (data access complete).
REQ-008 SHALL have ramREN  out  1, ramWEN  out  1, ramaddr  out  32 and ramstore  out  32 to drive the single RAM port.
REQ-009 SHALL have ramload  in  32 (RAM read data) and ramstate  in  2 (RAM status: 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR).
REQ-010 SHALL have wd_err  out  1: sticky watchdog flag.

Function
REQ-011 SHALL implement FSM states IDLE, DACC, IACC and RESP.
REQ-012 IDLE: if (dREN|dWEN) SHALL latch daddr, dstore and op, then go to DACC; else if iREN SHALL latch iaddr and go to IACC; else SHALL stay in IDLE.
REQ-013 Data requests SHALL take priority over instruction requests when both are present in the same IDLE cycle.
REQ-014 If dREN and dWEN are both high, the access SHALL be treated as a write.
REQ-015 DACC/IACC: SHALL drive ramaddr, ramstore, ramREN and ramWEN from the latched request only; the RAM strobes SHALL be 0 in IDLE and RESP.
REQ-016 ramstate==ACCESS: SHALL register ramload into dload (data read) or iload (instruction), then go to RESP.
REQ-017 ramstate FREE or BUSY: SHALL remain in the access state.
REQ-018 ramstate ERROR: SHALL return to IDLE with no hit pulse; the request is re-arbitrated from IDLE.
REQ-019 RESP: SHALL pulse dhit or ihit for exactly one cycle with the matching load output stable, then go to IDLE.
REQ-020 A hit SHALL never be asserted outside RESP, and ihit and dhit SHALL never be high together.
REQ-021 Minimum latency SHALL be request sampled in IDLE (cycle 0), ACCESS seen in cycle 1, hit in cycle 2.
REQ-022 A latched request SHALL complete and hit even if the requestor deasserts its request mid-access.
REQ-023 iload and dload SHALL hold their last captured value until the next capture of the same kind.
REQ-024 Back-to-back: an instruction request pending during a data access SHALL be accepted in the IDLE cycle after RESP, unless a data request is also present.

Reset
REQ-025 When nRST is low, the FSM SHALL be forced to IDLE immediately, even mid-access.
REQ-026 While nRST is low, iload, dload, ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, wd_err and the watchdog count SHALL all be 0.
REQ-027 A request interrupted by reset SHALL be dropped and produce no hit.

Configuration
REQ-028 With MEM_ARBITER_WATCHDOG_EN defined, a counter SHALL increment each cycle in DACC/IACC, clear on entry to those states and saturate at WD_LIMIT.
REQ-029 With MEM_ARBITER_WATCHDOG_EN defined, reaching WD_LIMIT SHALL set wd_err sticky until reset, and SHALL force the FSM to IDLE with no hit.
REQ-030 Without MEM_ARBITER_WATCHDOG_EN, there SHALL be no counter, wd_err SHALL be tied to 0, and the block SHALL wait on the RAM indefinitely.

Verification
REQ-031 iREN=1, iaddr=0x0000_0004, ramstate=ACCESS on cycle 1 with ramload=0x2001_0005 -> ihit high for exactly cycle 2, iload=0x2001_0005, ramREN high only in cycle 1.
REQ-032 iREN=1 and dWEN=1 in the same cycle, daddr=0x100, dstore=0xDEAD_BEEF -> write serviced first (ramWEN=1, ramaddr=0x100, ramstore=0xDEAD_BEEF), then dhit, then an IACC, then ihit.
REQ-033 dREN=1 with ramstate BUSY for 5 cycles then ACCESS with ramload=0x1234 -> dhit asserted 1 cycle after ACCESS, dload=0x1234, no hit pulse before that.
REQ-034 ramstate=ERROR during IACC -> return to IDLE, no ihit, request re-accepted the next cycle; nRST pulsed low mid-DACC -> all outputs 0 at once, no dhit after release.
REQ-035 With MEM_ARBITER_WATCHDOG_EN, WD_LIMIT=8 and ramstate held BUSY -> wd_err=1 after 8 access cycles, FSM in IDLE, wd_err stays 1 until nRST; without the macro -> wd_err=0 and the access is still pending after 1000 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data accesses win over instruction fetches, one request in flight.
// Optional access watchdog enabled by defining MEM_ARBITER_WATCHDOG_EN.
module mem_arbiter #(
  parameter int WD_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        wd_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [31:0] addr_reg, store_reg;
  logic        write_reg, data_reg;
  logic [31:0] iload_reg, dload_reg;
  logic        in_acc, ram_access, ram_error, timeout;

  assign in_acc     = (state_reg == DACC) || (state_reg == IACC);
  assign ram_access = (ramstate == RAM_ACCESS);
  assign ram_error  = (ramstate == RAM_ERROR);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (dREN || dWEN)
          state_next = DACC;
        else if (iREN)
          state_next = IACC;
      end
      DACC, IACC: begin
        if (ram_access)
          state_next = RESP;
        else if (ram_error || timeout)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      store_reg <= '0;
      write_reg <= 1'b0;
      data_reg  <= 1'b0;
      iload_reg <= '0;
      dload_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        if (dREN || dWEN) begin
          addr_reg  <= daddr;
          store_reg <= dstore;
          write_reg <= dWEN;
          data_reg  <= 1'b1;
        end else if (iREN) begin
          addr_reg  <= iaddr;
          store_reg <= '0;
          write_reg <= 1'b0;
          data_reg  <= 1'b0;
        end
      end
      if (ram_access && (state_reg == DACC) && !write_reg)
        dload_reg <= ramload;
      if (ram_access && (state_reg == IACC))
        iload_reg <= ramload;
    end
  end

  // RAM port is driven only from the latched request, never from live requestor inputs.
  assign ramREN   = (state_reg == IACC) || ((state_reg == DACC) && !write_reg);
  assign ramWEN   = (state_reg == DACC) && write_reg;
  assign ramaddr  = in_acc ? addr_reg : '0;
  assign ramstore = in_acc ? store_reg : '0;

  assign dhit  = (state_reg == RESP) && data_reg;
  assign ihit  = (state_reg == RESP) && !data_reg;
  assign iload = iload_reg;
  assign dload = dload_reg;

`ifdef MEM_ARBITER_WATCHDOG_EN
  localparam int CW = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT + 1);

  logic [CW-1:0] wd_cnt_reg;
  logic          wd_err_reg;

  // Fires on the WD_LIMIT-th access cycle unless the RAM resolves the access in that cycle.
  assign timeout = in_acc && !ram_access && !ram_error && ((int'(wd_cnt_reg) + 1) >= WD_LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt_reg <= '0;
      wd_err_reg <= 1'b0;
    end else begin
      // Access states are only entered from IDLE, so clearing there clears on entry.
      if (state_reg == IDLE)
        wd_cnt_reg <= '0;
      else if (in_acc && (int'(wd_cnt_reg) < WD_LIMIT))
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      if (timeout)
        wd_err_reg <= 1'b1;
    end
  end

  assign wd_err = wd_err_reg;
`else
  assign timeout = 1'b0;
  // Constant 0 for any legal WD_LIMIT; keeps the parameter referenced in this build.
  assign wd_err  = (WD_LIMIT < 0);
`endif

endmodule
